// File: rtl/status_encoding_if.sv
// rtl/status_encoding_if.sv - byte stream handshake between status encoder and serial transmitter
interface status_encoding_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/status_encoding.sv
// rtl/status_encoding.sv - queues board event pulses and encodes them as status bytes (optional CHECKSUM_EN adds a scan-frame checksum byte)
module status_encoding (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    move_done,
    input  logic                    magnet_state,
    input  logic                    magnet_ack,
    input  logic                    user_turn_done,
    input  logic                    user_draw,
    input  logic                    user_resign,
    input  logic                    new_game,
    input  logic                    scan_done,
    input  logic [63:0]             board_state,
    input  logic                    overflow_clr,
    output logic                    busy,
    output logic                    overflow,
    status_encoding_if.master       tx
);

    localparam logic [7:0] CODE_MOVE     = 8'h00;
    localparam logic [7:0] CODE_MAG_ON   = 8'h60;
    localparam logic [7:0] CODE_MAG_OFF  = 8'h40;
    localparam logic [7:0] CODE_TURN     = 8'hC0;
    localparam logic [7:0] CODE_DRAW     = 8'hC4;
    localparam logic [7:0] CODE_RESIGN   = 8'hC8;
    localparam logic [7:0] CODE_NEW_GAME = 8'hBC;
    localparam logic [7:0] CODE_SCAN     = 8'hBF;

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, ROWS, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, ROWS} state_t;
`endif

    state_t      state;
    state_t      state_n;
    logic [2:0]  row;
    logic [2:0]  row_n;
    logic [2:0]  row_inc;
    logic [7:0]  data_n;
    logic        valid_n;
    logic        xfer;

    // Flag bit order doubles as priority order: bit 0 is served first.
    logic [6:0]  pulses;
    logic [6:0]  flags;
    logic [6:0]  clr;
    logic [6:0]  lost;
    logic        mag_val;
    logic [63:0] pending;
    logic [63:0] frame;

    assign pulses  = {scan_done, new_game, user_resign, user_draw,
                      user_turn_done, magnet_ack, move_done};
    assign lost    = pulses & flags & ~clr;
    assign xfer    = tx.tx_valid & tx.tx_ready;
    assign row_inc = row + 3'd1;
    assign busy    = (|flags) | (state != IDLE);

`ifdef CHECKSUM_EN
    logic [7:0] csum;

    // Checksum covers the header byte and all eight row bytes of the frame in flight.
    always_comb begin
        csum = CODE_SCAN;
        for (int i = 0; i < 8; i++) begin
            csum = csum ^ frame[8*i +: 8];
        end
    end
`endif

    // Next-state and next-output decode; only IDLE picks new work, other states advance on transfer.
    always_comb begin
        state_n = state;
        row_n   = row;
        data_n  = tx.tx_data;
        valid_n = tx.tx_valid;
        clr     = '0;
        case (state)
            IDLE: begin
                if (|flags) begin
                    valid_n = 1'b1;
                    state_n = SEND;
                    if (flags[0]) begin
                        clr[0] = 1'b1;
                        data_n = CODE_MOVE;
                    end else if (flags[1]) begin
                        clr[1] = 1'b1;
                        data_n = mag_val ? CODE_MAG_ON : CODE_MAG_OFF;
                    end else if (flags[2]) begin
                        clr[2] = 1'b1;
                        data_n = CODE_TURN;
                    end else if (flags[3]) begin
                        clr[3] = 1'b1;
                        data_n = CODE_DRAW;
                    end else if (flags[4]) begin
                        clr[4] = 1'b1;
                        data_n = CODE_RESIGN;
                    end else if (flags[5]) begin
                        clr[5] = 1'b1;
                        data_n = CODE_NEW_GAME;
                    end else begin
                        clr[6] = 1'b1;
                        data_n = CODE_SCAN;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (tx.tx_data == CODE_SCAN) begin
                        // Row 0 follows the header back-to-back; frame was captured at selection.
                        state_n = ROWS;
                        row_n   = 3'd0;
                        data_n  = frame[7:0];
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            ROWS: begin
                if (xfer) begin
                    if (row == 3'd7) begin
`ifdef CHECKSUM_EN
                        state_n = CSUM;
                        data_n  = csum;
`else
                        valid_n = 1'b0;
                        state_n = IDLE;
`endif
                    end else begin
                        row_n  = row_inc;
                        data_n = frame[{row_inc, 3'b000} +: 8];
                    end
                end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // FSM state, row counter and the registered byte stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= 3'd0;
            tx.tx_data  <= 8'h00;
            tx.tx_valid <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            tx.tx_data  <= data_n;
            tx.tx_valid <= valid_n;
        end
    end

    // Sticky pending flags; a pulse landing on its own clear edge re-arms the flag without loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags    <= '0;
            overflow <= 1'b0;
        end else begin
            flags    <= pulses | (flags & ~clr);
            overflow <= (overflow & ~overflow_clr) | (|lost);
        end
    end

    // Event payloads: latest magnet level, newest scan in pending, frame frozen at selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_val <= 1'b0;
            pending <= '0;
            frame   <= '0;
        end else begin
            if (magnet_ack) begin
                mag_val <= magnet_state;
            end
            if (scan_done) begin
                pending <= board_state;
            end
            if (clr[6]) begin
                frame <= pending;
            end
        end
    end

endmodule

// File: tb/tb_status_encoding.sv
// tb/tb_status_encoding.sv - randomized and directed bench for status_encoding against a queue-based model
module tb_status_encoding;

    localparam logic [6:0] EV_MOVE   = 7'b000_0001;
    localparam logic [6:0] EV_MAG    = 7'b000_0010;
    localparam logic [6:0] EV_TURN   = 7'b000_0100;
    localparam logic [6:0] EV_DRAW   = 7'b000_1000;
    localparam logic [6:0] EV_RESIGN = 7'b001_0000;
    localparam logic [6:0] EV_NEW    = 7'b010_0000;
    localparam logic [6:0] EV_SCAN   = 7'b100_0000;

    logic        clk;
    logic        rst_n;
    logic [6:0]  ev;
    logic        magnet_state;
    logic [63:0] board_state;
    logic        overflow_clr;
    logic        busy;
    logic        overflow;

    status_encoding_if bus ();

    status_encoding dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .move_done      (ev[0]),
        .magnet_state   (magnet_state),
        .magnet_ack     (ev[1]),
        .user_turn_done (ev[2]),
        .user_draw      (ev[3]),
        .user_resign    (ev[4]),
        .new_game       (ev[5]),
        .scan_done      (ev[6]),
        .board_state    (board_state),
        .overflow_clr   (overflow_clr),
        .busy           (busy),
        .overflow       (overflow),
        .tx             (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: pending events as a set, outgoing message as a byte queue.
    logic        m_pend [7];
    logic        m_mag;
    logic [63:0] m_board;
    logic [7:0]  m_msg [$];
    logic        m_ovf;

    logic [7:0]  sent [$];
    logic [7:0]  exp_bytes [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_pend[i] = 1'b0;
        m_mag   = 1'b0;
        m_board = '0;
        m_msg.delete();
        m_ovf   = 1'b0;
    endtask

    function automatic logic [7:0] event_code(input int idx, input logic mag);
        case (idx)
            0:       return 8'h00;
            1:       return mag ? 8'h60 : 8'h40;
            2:       return 8'hC0;
            3:       return 8'hC4;
            4:       return 8'hC8;
            5:       return 8'hBC;
            default: return 8'hBF;
        endcase
    endfunction

    task automatic add_scan_bytes(input logic [63:0] b);
        logic [7:0] x;
        logic [7:0] q [$];
        q.push_back(8'hBF);
        x = 8'hBF;
        for (int r = 0; r < 8; r++) begin
            q.push_back(b[8*r +: 8]);
            x = x ^ b[8*r +: 8];
        end
`ifdef CHECKSUM_EN
        q.push_back(x);
`endif
        foreach (q[i]) exp_bytes.push_back(q[i]);
    endtask

    // One clock edge of the model, using the inputs the DUT sees at that edge.
    task automatic model_edge();
        int sel;
        sel = -1;
        if (m_msg.size() > 0) begin
            if (bus.tx_ready) void'(m_msg.pop_front());
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (m_pend[i] && sel < 0) sel = i;
            end
        end
        if (sel == 6) begin
            m_msg.push_back(8'hBF);
            for (int r = 0; r < 8; r++) m_msg.push_back(m_board[8*r +: 8]);
`ifdef CHECKSUM_EN
            begin
                logic [7:0] x;
                x = 8'hBF;
                for (int r = 0; r < 8; r++) x = x ^ m_board[8*r +: 8];
                m_msg.push_back(x);
            end
`endif
        end else if (sel >= 0) begin
            m_msg.push_back(event_code(sel, m_mag));
        end
        if (sel >= 0) m_pend[sel] = 1'b0;
        if (overflow_clr) m_ovf = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (ev[i]) begin
                if (m_pend[i]) m_ovf = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        if (ev[1]) m_mag = magnet_state;
        if (ev[6]) m_board = board_state;
    endtask

    task automatic compare_outputs();
        logic any;
        any = 1'b0;
        for (int i = 0; i < 7; i++) any = any | m_pend[i];
        check("tx_valid", bus.tx_valid, m_msg.size() != 0);
        if (m_msg.size() != 0) check("tx_data", bus.tx_data, m_msg[0]);
        check("busy", busy, any || (m_msg.size() != 0));
        check("overflow", overflow, m_ovf);
    endtask

    // Drive at the falling edge, let the DUT and model take the rising edge, compare at the next falling edge.
    task automatic cycle(input logic [6:0] pulses, input logic rdy);
        ev           = pulses;
        bus.tx_ready = rdy;
        if (bus.tx_valid && rdy) sent.push_back(bus.tx_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
        ev           = '0;
        overflow_clr = 1'b0;
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_len"}, sent.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < sent.size(); i++)
            check(tag, sent[i], exp_bytes[i]);
        sent.delete();
        exp_bytes.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        ev           = '0;
        magnet_state = 1'b0;
        board_state  = '0;
        overflow_clr = 1'b0;
        bus.tx_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", bus.tx_valid, 1'b0);
        check("rst_data", bus.tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // Single turn-done: byte visible after the second edge, then busy drops.
        cycle(EV_TURN, 1'b1);
        check("turn_lat1", bus.tx_valid, 1'b0);
        cycle('0, 1'b1);
        check("turn_lat2_valid", bus.tx_valid, 1'b1);
        check("turn_lat2_data", bus.tx_data, 8'hC0);
        for (int i = 0; i < 4; i++) cycle('0, 1'b1);
        check("turn_busy_end", busy, 1'b0);
        exp_bytes.push_back(8'hC0);
        compare_log("turn");

        // Three simultaneous events go out in priority order with gaps.
        magnet_state = 1'b1;
        cycle(EV_MOVE | EV_MAG | EV_NEW, 1'b1);
        magnet_state = 1'b0;
        for (int i = 0; i < 12; i++) cycle('0, 1'b1);
        exp_bytes = '{8'h00, 8'h60, 8'hBC};
        compare_log("three");
        check("three_ovf", overflow, 1'b0);

        // Scan frame under a toggling ready.
        board_state = 64'h0102_0408_1020_4080;
        cycle(EV_SCAN, 1'b0);
        for (int i = 0; i < 30; i++) cycle('0, i[0]);
        add_scan_bytes(64'h0102_0408_1020_4080);
        compare_log("scan");

        // New scan while rows are in flight must not disturb the current frame.
        board_state = 64'h1122_3344_5566_7788;
        cycle(EV_SCAN, 1'b1);
        for (int i = 0; i < 4; i++) cycle('0, 1'b1);
        board_state = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle(EV_SCAN, 1'b1);
        for (int i = 0; i < 30; i++) cycle('0, 1'b1);
        add_scan_bytes(64'h1122_3344_5566_7788);
        add_scan_bytes(64'hFFFF_FFFF_FFFF_FFFF);
        compare_log("scan2");
        check("scan2_ovf", overflow, 1'b0);

        // Stalled draws: the third pulse finds the flag still pending.
        cycle(EV_DRAW, 1'b0);
        for (int i = 0; i < 3; i++) cycle('0, 1'b0);
        cycle(EV_DRAW, 1'b0);
        cycle('0, 1'b0);
        cycle(EV_DRAW, 1'b0);
        check("draw_ovf", overflow, 1'b1);
        for (int i = 0; i < 8; i++) cycle('0, 1'b1);
        exp_bytes = '{8'hC4, 8'hC4};
        compare_log("draw");
        overflow_clr = 1'b1;
        cycle('0, 1'b1);
        check("ovf_clr", overflow, 1'b0);

        // Async reset in the middle of a frame with overflow set.
        cycle(EV_SCAN, 1'b0);
        cycle('0, 1'b0);
        cycle(EV_MOVE, 1'b0);
        cycle(EV_MOVE, 1'b0);
        check("pre_rst_ovf", overflow, 1'b1);
        for (int i = 0; i < 4; i++) cycle('0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.tx_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sent.delete();
        for (int i = 0; i < 5; i++) cycle('0, 1'b1);
        check("post_rst_quiet", sent.size(), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] p;
            p = '0;
            for (int i = 0; i < 7; i++) p[i] = ($urandom_range(0, 19) == 0);
            magnet_state = $urandom_range(0, 1) == 1;
            board_state  = {$urandom, $urandom};
            overflow_clr = ($urandom_range(0, 31) == 0);
            cycle(p, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
